game_stacker_param: RTL and testbench

Parametrised successor to the fixed 8x8 stacker game core. A block of configurable width slides back and forth on the current row. The player locks it with the place button, and only the part that overlaps the row below survives. The game speeds up as the stack grows and ends on a miss or on a full stack (win). The block sits between the game-select FSM (start, userid), the button debouncers and the LED-matrix / score-reporting path.

---
 rtl/game_stacker_param_if.sv | 24 ++
 rtl/game_stacker_param.sv | 155 +++++++++++++++
 tb/tb_game_stacker_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/game_stacker_param_if.sv
// Player-facing bus of the stacker core: timer/button inputs, display and score outputs.
interface game_stacker_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                     tick;
  logic                     start;
  logic                     place;
  logic [15:0]              userid;
  logic                     game_eog;
  logic                     game_win;
  logic [WIDTH*DEPTH-1:0]   game_display;
  logic [31:0]              game_data;

  modport master (
    output tick, start, place, userid,
    input  game_eog, game_win, game_display, game_data
  );

  modport slave (
    input  tick, start, place, userid,
    output game_eog, game_win, game_display, game_data
  );
endinterface

// File: rtl/game_stacker_param.sv
// Stacker game core: a block slides on the active row, place keeps only the overlap with the row below.
module game_stacker_param #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int BLOCK_W     = 3,
  parameter int BASE_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  game_stacker_param_if.slave  bus
);
  localparam int RW = $clog2(DEPTH);
  localparam int CW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam logic [WIDTH-1:0] SPAWN = ~({WIDTH{1'b1}} >> BLOCK_W);
  localparam logic [RW-1:0] TOP = RW'(DEPTH - 1);
  localparam logic [RW-1:0] ONE = RW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

  state_t                        state;
  logic [DEPTH-1:0][WIDTH-1:0]   rows;
  logic [15:0]                   score;
  logic                          eog;
  logic                          win;
  logic [RW-1:0]                 row_idx;
  logic                          dir;
  logic [CW-1:0]                 cnt;
  logic                          place_q;

  logic                          place_rise;
  logic [WIDTH-1:0]              active;
  logic [WIDTH-1:0]              below;
  logic [WIDTH-1:0]              overlap;
  logic [WIDTH-1:0]              moved;
  logic                          next_dir;
  logic [CW-1:0]                 cnt_last;
  int                            period;

  function automatic logic [15:0] popcount(input logic [WIDTH-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign place_rise = bus.place & ~place_q;
  assign active     = rows[row_idx];
  // Row 0 sits on the floor, so everything it covers survives.
  assign below      = (row_idx == '0) ? '1 : rows[row_idx - ONE];
  assign overlap    = active & below;

  always_comb begin
    period = BASE_PERIOD - int'(row_idx);
    if (period < 1) period = 1;
    cnt_last = CW'(period - 1);
  end

  // Edge cells bounce in the same move rather than idling a step.
  always_comb begin
    moved    = active;
    next_dir = dir;
    if (dir == DIR_RIGHT) begin
      if (active[0]) begin
        next_dir = DIR_LEFT;
        moved    = active << 1;
      end else begin
        moved    = active >> 1;
      end
    end else begin
      if (active[WIDTH-1]) begin
        next_dir = DIR_RIGHT;
        moved    = active >> 1;
      end else begin
        moved    = active << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rows    <= '0;
      score   <= '0;
      eog     <= 1'b0;
      win     <= 1'b0;
      row_idx <= '0;
      dir     <= DIR_RIGHT;
      cnt     <= '0;
      place_q <= 1'b0;
    end else begin
      place_q <= bus.place;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            rows    <= '0;
            rows[0] <= SPAWN;
            score   <= '0;
            eog     <= 1'b0;
            win     <= 1'b0;
            row_idx <= '0;
            dir     <= DIR_RIGHT;
            cnt     <= '0;
            state   <= MOVE;
          end
        end
        MOVE: begin
          if (place_rise) begin
            if (overlap == '0) begin
              rows[row_idx] <= '0;
              eog           <= 1'b1;
              win           <= 1'b0;
              state         <= DONE;
            end else begin
              rows[row_idx] <= overlap;
              score         <= sat_add(score, popcount(overlap));
              if (row_idx == TOP) begin
                eog   <= 1'b1;
                win   <= 1'b1;
                state <= DONE;
              end else begin
                rows[row_idx + ONE] <= overlap;
                row_idx             <= row_idx + ONE;
                dir                 <= DIR_RIGHT;
                cnt                 <= '0;
              end
            end
          end else if (bus.tick) begin
            if (cnt == cnt_last) begin
              cnt           <= '0;
              rows[row_idx] <= moved;
              dir           <= next_dir;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.game_display = rows;
  assign bus.game_data    = {bus.userid, score};
  assign bus.game_eog     = eog;
  assign bus.game_win     = win;
endmodule

// File: tb/tb_game_stacker_param.sv
// Directed bench for game_stacker_param with the default 8x8, 3-wide, period-4 configuration.
module tb_game_stacker_param;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  game_stacker_param_if #(.WIDTH(8), .DEPTH(8)) bus ();

  game_stacker_param #(
    .WIDTH(8), .DEPTH(8), .BLOCK_W(3), .BASE_PERIOD(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input logic [63:0] disp, input logic [15:0] score,
                             input logic eog, input logic win);
    check({tag, "_disp"}, bus.game_display, disp);
    check({tag, "_data"}, 64'(bus.game_data), 64'({16'hBEEF, score}));
    check({tag, "_eog"}, 64'(bus.game_eog), 64'(eog));
    check({tag, "_win"}, 64'(bus.game_win), 64'(win));
  endtask

  task automatic restart();
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    bus.tick   = 1'b0;
    bus.start  = 1'b0;
    bus.place  = 1'b0;
    bus.userid = 16'hBEEF;
    cyc(2);
    check_state("reset", 64'h0, 16'd0, 1'b0, 1'b0);

    // 1. start spawns row 0 left-aligned
    rst = 1'b1;
    cyc(1);
    check_state("idle", 64'h0, 16'd0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_state("spawn", 64'hE0, 16'd0, 1'b0, 1'b0);

    // 2. row 0 moves every 4 ticks, then bounces off the right edge
    bus.tick = 1'b1;
    cyc(3);
    check("no_move_3ticks", bus.game_display, 64'hE0);
    cyc(1);
    check("move_4ticks", bus.game_display, 64'h70);
    cyc(16);
    check("right_edge", bus.game_display, 64'h07);
    cyc(4);
    check("bounce", bus.game_display, 64'h0E);
    bus.tick = 1'b0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("start_in_move", bus.game_display, 64'h0E);

    // 3. full place on row 0; row 1 period is 3
    restart();
    bus.place = 1'b1;
    cyc(1);
    bus.place = 1'b0;
    check_state("place_row0", 64'hE0E0, 16'd3, 1'b0, 1'b0);
    bus.tick = 1'b1;
    cyc(2);
    check("row1_2ticks", bus.game_display, 64'hE0E0);
    cyc(1);
    check("row1_3ticks", bus.game_display, 64'h70E0);

    // 4. partial overlap, place wins over a simultaneous tick
    bus.place = 1'b1;
    cyc(1);
    check_state("partial", 64'h6060E0, 16'd5, 1'b0, 1'b0);
    cyc(1);
    check_state("held_place", 64'h6060E0, 16'd5, 1'b0, 1'b0);
    cyc(1);
    check_state("row2_move", 64'h3060E0, 16'd5, 1'b0, 1'b0);
    bus.place = 1'b0;
    bus.tick  = 1'b0;

    // 5. miss ends the game, DONE ignores place/tick, start restarts
    restart();
    bus.place = 1'b1;
    cyc(1);
    bus.place = 1'b0;
    bus.tick  = 1'b1;
    cyc(9);
    bus.tick  = 1'b0;
    check("row1_at_1C", bus.game_display, 64'h1CE0);
    bus.place = 1'b1;
    cyc(1);
    check_state("miss", 64'hE0, 16'd3, 1'b1, 1'b0);
    bus.tick  = 1'b1;
    bus.place = 1'b0;
    cyc(1);
    bus.place = 1'b1;
    cyc(1);
    bus.place = 1'b0;
    cyc(5);
    bus.tick  = 1'b0;
    check_state("done_hold", 64'hE0, 16'd3, 1'b1, 1'b0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check_state("restart", 64'hE0, 16'd0, 1'b0, 1'b0);

    // 6. eight stationary places win the game
    for (int i = 0; i < 8; i++) begin
      bus.place = 1'b1;
      cyc(1);
      bus.place = 1'b0;
      cyc(1);
      if (i == 3) check_state("half_stack", 64'hE0E0E0E0E0, 16'd12, 1'b0, 1'b0);
    end
    check_state("win", 64'hE0E0E0E0E0E0E0E0, 16'd24, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(1);
    check_state("reset_after_win", 64'h0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
